riscv_i32_fetch_req_bht: RTL and testbench

Next-generation instruction-fetch request generator for the i32 pipeline. It produces the same ifetch request bundle as today's fetch-request logic. Static backward-taken prediction for conditional branches is replaced by a parametrised branch history table (BHT) of saturating counters, trained from execute-stage resolution. It sits between pipeline control/decode and the ifetch port; the BHT, its initialisation sequencer and the optional statistics counters are the only state.

---
 rtl/riscv_i32_fetch_req_bht.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_riscv_i32_fetch_req_bht.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_i32_fetch_req_bht.sv
// -----------------------------------------------------------------------------
// riscv_i32_fetch_req_bht
//
// Instruction-fetch request generator for the i32 pipeline, with a branch
// history table (BHT) of saturating counters for dynamic conditional-branch
// prediction. The BHT is trained by execute-stage resolutions.
//
// Optional feature macro: RISCV_I32_FETCH_REQ_BHT_STATS_EN
//   When defined, two 32-bit statistics counters are added:
//   stat_resolved (resolutions seen in RUN) and stat_mispredicted.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   bht_flush                    pulse: restart table initialisation
//   fetch_action[2:0]            0 none/flush, 1 idle, 2 restart, 3 next (any), 4 sequential next
//   decode_*                     instruction in decode (pc, op, size, imm sign, target)
//   enable_bp                    branch prediction enable
//   mode[2:0]                    privilege mode (7 = debug)
//   exec_resolve_*               branch resolution from execute (valid, pc, taken)
//   ifetch_req__*                ifetch request bundle
//   bht_ready                    table initialised, predictions live
//   stat_resolved/mispredicted   statistics (only with the macro above)
// -----------------------------------------------------------------------------
module riscv_i32_fetch_req_bht #(
    parameter int unsigned BHT_LOG2      = 4,
    parameter int unsigned CTR_WIDTH     = 2,
    parameter logic [23:0] DEBUG_ADDR_HI = 24'hffffff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bht_flush,
    input  logic [2:0]  fetch_action,
    input  logic [31:0] decode_pc,
    input  logic [3:0]  decode_op,
    input  logic        decode_is_compressed,
    input  logic        decode_imm_sign,
    input  logic [31:0] decode_branch_target,
    input  logic        enable_bp,
    input  logic [2:0]  mode,
    input  logic        exec_resolve_valid,
    input  logic [31:0] exec_resolve_pc,
    input  logic        exec_branch_taken,
    output logic        ifetch_req__flush_pipeline,
    output logic [2:0]  ifetch_req__req_type,
    output logic        ifetch_req__debug_fetch,
    output logic [31:0] ifetch_req__address,
    output logic [2:0]  ifetch_req__mode,
    output logic        ifetch_req__predicted_branch,
    output logic [31:0] ifetch_req__pc_if_mispredicted,
    output logic        bht_ready
`ifdef RISCV_I32_FETCH_REQ_BHT_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredicted
`endif
);

    localparam int unsigned         BHT_ENTRIES = 32'd1 << BHT_LOG2;
    localparam logic [BHT_LOG2-1:0] LAST_IDX    = BHT_LOG2'(BHT_ENTRIES - 32'd1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX    = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_MIN    = {CTR_WIDTH{1'b0}};
    // Weakly not-taken: MSB clear, every lower bit set.
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT =
        CTR_WIDTH'((32'd1 << (CTR_WIDTH - 32'd1)) - 32'd1);

    localparam logic [2:0] REQ_NONE        = 3'd0;
    localparam logic [2:0] REQ_NONSEQ      = 3'd1;
    localparam logic [2:0] REQ_SEQ32       = 3'd2;
    localparam logic [2:0] REQ_NONSEQ_NEXT = 3'd3;
    localparam logic [2:0] REQ_SEQ16       = 3'd6;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_t;

    // Saturating increment/decrement of a prediction counter.
    function automatic logic [CTR_WIDTH-1:0] ctr_next(
        input logic [CTR_WIDTH-1:0] ctr,
        input logic                 up
    );
        logic [CTR_WIDTH-1:0] res;
        if (up) begin
            if (ctr == CTR_MAX) res = ctr;
            else                res = ctr + CTR_WIDTH'(1'b1);
        end else begin
            if (ctr == CTR_MIN) res = ctr;
            else                res = ctr - CTR_WIDTH'(1'b1);
        end
        return res;
    endfunction

    init_state_t           state_r;
    init_state_t           state_s;
    logic [BHT_LOG2-1:0]   init_idx_r;
    logic [CTR_WIDTH-1:0]  bht_r [BHT_ENTRIES];

    logic                  bht_we_s;
    logic [BHT_LOG2-1:0]   bht_widx_s;
    logic [CTR_WIDTH-1:0]  bht_wdata_s;
    logic [BHT_LOG2-1:0]   resolve_idx_s;
    logic [CTR_WIDTH-1:0]  resolve_ctr_s;
    logic [BHT_LOG2-1:0]   lookup_idx_s;
    logic                  lookup_msb_s;

    logic [31:0]           pc_plus_inst_s;
    logic                  taken_s;
    logic [31:0]           next_pc_s;
    logic [31:0]           pc_if_mispredicted_s;
    logic                  flush_s;
    logic [2:0]            req_type_s;
    logic [31:0]           address_s;
    logic                  debug_s;
    logic                  ready_s;
    logic                  unused_s;

    assign unused_s = ^{exec_resolve_pc[31:BHT_LOG2+1], exec_resolve_pc[0]};

    // Init FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Init FSM next state: flush always restarts, INIT ends after the last entry.
    always_comb begin
        state_s = state_r;
        if (bht_flush) begin
            state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_idx_r == LAST_IDX) state_s = ST_RUN;
                    else                        state_s = ST_INIT;
                end
                ST_RUN:  state_s = ST_RUN;
                default: state_s = ST_INIT;
            endcase
        end
    end

    // Init FSM outputs: predictions are live only in RUN.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_RUN:  ready_s = 1'b1;
            ST_INIT: ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    assign bht_ready = ready_s;

    // Init index counter: walks the table during INIT, cleared on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_idx_r <= {BHT_LOG2{1'b0}};
        end else if (bht_flush) begin
            init_idx_r <= {BHT_LOG2{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_idx_r <= init_idx_r + BHT_LOG2'(1'b1);
        end else begin
            init_idx_r <= {BHT_LOG2{1'b0}};
        end
    end

    // Table write port: init fill in INIT, resolution training in RUN.
    always_comb begin
        bht_we_s      = 1'b0;
        bht_widx_s    = {BHT_LOG2{1'b0}};
        bht_wdata_s   = CTR_WEAK_NT;
        resolve_idx_s = exec_resolve_pc[BHT_LOG2:1];
        resolve_ctr_s = bht_r[resolve_idx_s];
        if (bht_flush) begin
            bht_we_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            bht_we_s    = 1'b1;
            bht_widx_s  = init_idx_r;
            bht_wdata_s = CTR_WEAK_NT;
        end else if (exec_resolve_valid) begin
            bht_we_s    = 1'b1;
            bht_widx_s  = resolve_idx_s;
            bht_wdata_s = ctr_next(resolve_ctr_s, exec_branch_taken);
        end else begin
            bht_we_s = 1'b0;
        end
    end

    // Counter storage; contents are meaningless until INIT has filled it.
    always_ff @(posedge clk) begin
        if (bht_we_s) begin
            bht_r[bht_widx_s] <= bht_wdata_s;
        end
    end

    // Direction prediction; the lookup sees the counter before this cycle's update.
    always_comb begin
        lookup_idx_s   = decode_pc[BHT_LOG2:1];
        lookup_msb_s   = bht_r[lookup_idx_s][CTR_WIDTH-1];
        pc_plus_inst_s = decode_pc + (decode_is_compressed ? 32'd2 : 32'd4);
        taken_s        = 1'b0;
        if (enable_bp) begin
            case (decode_op)
                4'd0: begin
                    // Before the table is ready, fall back to backward-taken.
                    if (state_r == ST_RUN) taken_s = lookup_msb_s;
                    else                   taken_s = decode_imm_sign;
                end
                4'd1:    taken_s = 1'b1;
                default: taken_s = 1'b0;
            endcase
        end else begin
            taken_s = 1'b0;
        end
        if (taken_s) begin
            next_pc_s            = decode_branch_target;
            pc_if_mispredicted_s = pc_plus_inst_s;
        end else begin
            next_pc_s            = pc_plus_inst_s;
            pc_if_mispredicted_s = decode_branch_target;
        end
    end

    // Fetch request decode with debug-fetch override.
    always_comb begin
        flush_s    = 1'b1;
        req_type_s = REQ_NONE;
        address_s  = 32'd0;
        debug_s    = 1'b0;
        case (fetch_action)
            3'd1: begin
                flush_s    = 1'b0;
                req_type_s = REQ_NONE;
                address_s  = 32'd0;
            end
            3'd2: begin
                flush_s    = 1'b1;
                req_type_s = REQ_NONSEQ;
                address_s  = decode_pc;
            end
            3'd3: begin
                flush_s    = 1'b0;
                req_type_s = REQ_NONSEQ_NEXT;
                address_s  = next_pc_s;
            end
            3'd4: begin
                flush_s   = 1'b0;
                address_s = next_pc_s;
                if (taken_s)                   req_type_s = REQ_NONSEQ;
                else if (decode_is_compressed) req_type_s = REQ_SEQ16;
                else                           req_type_s = REQ_SEQ32;
            end
            default: begin
                flush_s    = 1'b1;
                req_type_s = REQ_NONE;
                address_s  = 32'd0;
            end
        endcase
        if ((mode == 3'd7) && (fetch_action != 3'd0) && (fetch_action != 3'd1) &&
            (address_s[31:8] == DEBUG_ADDR_HI)) begin
            req_type_s = REQ_NONE;
            debug_s    = 1'b1;
        end else begin
            debug_s = 1'b0;
        end
    end

    assign ifetch_req__flush_pipeline     = flush_s;
    assign ifetch_req__req_type           = req_type_s;
    assign ifetch_req__debug_fetch        = debug_s;
    assign ifetch_req__address            = address_s;
    assign ifetch_req__mode               = 3'd0;
    assign ifetch_req__predicted_branch   = taken_s;
    assign ifetch_req__pc_if_mispredicted = pc_if_mispredicted_s;

`ifdef RISCV_I32_FETCH_REQ_BHT_STATS_EN
    logic        stat_count_s;
    logic        stat_miss_s;
    logic [31:0] stat_resolved_r;
    logic [31:0] stat_mispredicted_r;

    assign stat_count_s = exec_resolve_valid & (state_r == ST_RUN);
    assign stat_miss_s  = stat_count_s & (exec_branch_taken != resolve_ctr_s[CTR_WIDTH-1]);

    // Statistics counters, wrapping at 2^32 and cleared by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_resolved_r     <= 32'd0;
            stat_mispredicted_r <= 32'd0;
        end else if (bht_flush) begin
            stat_resolved_r     <= 32'd0;
            stat_mispredicted_r <= 32'd0;
        end else begin
            stat_resolved_r     <= stat_resolved_r + {31'd0, stat_count_s};
            stat_mispredicted_r <= stat_mispredicted_r + {31'd0, stat_miss_s};
        end
    end

    assign stat_resolved     = stat_resolved_r;
    assign stat_mispredicted = stat_mispredicted_r;
`endif

endmodule

// File: tb/tb_riscv_i32_fetch_req_bht.sv
// -----------------------------------------------------------------------------
// Self-checking bench for riscv_i32_fetch_req_bht (BHT_LOG2=4, CTR_WIDTH=2).
// A table of decode vectors checks the combinational request logic, hand
// sequences cover init timing, training, saturation and flush, and a random
// phase compares every cycle against a behavioural model of the table.
// -----------------------------------------------------------------------------
module tb_riscv_i32_fetch_req_bht;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bht_flush;
    logic [2:0]  fetch_action;
    logic [31:0] decode_pc;
    logic [3:0]  decode_op;
    logic        decode_is_compressed;
    logic        decode_imm_sign;
    logic [31:0] decode_branch_target;
    logic        enable_bp;
    logic [2:0]  mode;
    logic        exec_resolve_valid;
    logic [31:0] exec_resolve_pc;
    logic        exec_branch_taken;
    logic        o_flush;
    logic [2:0]  o_type;
    logic        o_debug;
    logic [31:0] o_addr;
    logic [2:0]  o_mode;
    logic        o_pred;
    logic [31:0] o_pcm;
    logic        bht_ready;
`ifdef RISCV_I32_FETCH_REQ_BHT_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredicted;
`endif

    always #5 clk = ~clk;

    riscv_i32_fetch_req_bht dut (
        .clk                            (clk),
        .reset_n                        (reset_n),
        .bht_flush                      (bht_flush),
        .fetch_action                   (fetch_action),
        .decode_pc                      (decode_pc),
        .decode_op                      (decode_op),
        .decode_is_compressed           (decode_is_compressed),
        .decode_imm_sign                (decode_imm_sign),
        .decode_branch_target           (decode_branch_target),
        .enable_bp                      (enable_bp),
        .mode                           (mode),
        .exec_resolve_valid             (exec_resolve_valid),
        .exec_resolve_pc                (exec_resolve_pc),
        .exec_branch_taken              (exec_branch_taken),
        .ifetch_req__flush_pipeline     (o_flush),
        .ifetch_req__req_type           (o_type),
        .ifetch_req__debug_fetch        (o_debug),
        .ifetch_req__address            (o_addr),
        .ifetch_req__mode               (o_mode),
        .ifetch_req__predicted_branch   (o_pred),
        .ifetch_req__pc_if_mispredicted (o_pcm),
        .bht_ready                      (bht_ready)
`ifdef RISCV_I32_FETCH_REQ_BHT_STATS_EN
        ,
        .stat_resolved                  (stat_resolved),
        .stat_mispredicted              (stat_mispredicted)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: counters as plain integers 0..3.
    int          m_ctr [16];
    bit          m_init;
    int          m_written;
    logic [31:0] m_res;
    logic [31:0] m_mis;

    typedef struct {
        logic [2:0]  act;
        logic [31:0] pc;
        logic [3:0]  op;
        logic        comp;
        logic        imm;
        logic [31:0] tgt;
        logic        en;
        logic [2:0]  md;
        logic        flush;
        logic [2:0]  typ;
        logic        dbg;
        logic [31:0] addr;
        logic        pred;
        logic [31:0] pcm;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init    = 1'b1;
        m_written = 0;
        m_res     = 32'd0;
        m_mis     = 32'd0;
    endtask

    // Apply one clock edge's worth of state change using the current inputs.
    task automatic model_update();
        int idx;
        bit old_taken;
        if (bht_flush) begin
            model_reset();
        end else if (m_init) begin
            m_ctr[m_written] = 1;
            m_written++;
            if (m_written == 16) m_init = 1'b0;
        end else if (exec_resolve_valid) begin
            idx = int'((exec_resolve_pc >> 1) % 32'd16);
            old_taken = (m_ctr[idx] >= 2);
            m_res = m_res + 32'd1;
            if (old_taken != exec_branch_taken) m_mis = m_mis + 32'd1;
            if (exec_branch_taken) m_ctr[idx] = (m_ctr[idx] >= 3) ? 3 : m_ctr[idx] + 1;
            else                   m_ctr[idx] = (m_ctr[idx] <= 0) ? 0 : m_ctr[idx] - 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Compare all outputs against what the model says they must be now.
    task automatic check_model(input string tag);
        logic [31:0] ppi, nxt, pcm, addr;
        logic [2:0]  typ;
        bit          taken, flush, dbg;
        ppi   = decode_pc + (decode_is_compressed ? 32'd2 : 32'd4);
        taken = 1'b0;
        if (enable_bp && decode_op == 4'd1) taken = 1'b1;
        if (enable_bp && decode_op == 4'd0)
            taken = m_init ? decode_imm_sign : (m_ctr[int'((decode_pc >> 1) % 32'd16)] >= 2);
        nxt   = taken ? decode_branch_target : ppi;
        pcm   = taken ? ppi : decode_branch_target;
        flush = 1'b1;
        typ   = 3'd0;
        addr  = 32'd0;
        if (fetch_action == 3'd1) flush = 1'b0;
        if (fetch_action == 3'd2) begin typ = 3'd1; addr = decode_pc; end
        if (fetch_action == 3'd3) begin flush = 1'b0; typ = 3'd3; addr = nxt; end
        if (fetch_action == 3'd4) begin
            flush = 1'b0;
            addr  = nxt;
            typ   = taken ? 3'd1 : (decode_is_compressed ? 3'd6 : 3'd2);
        end
        dbg = (mode == 3'd7) && (fetch_action >= 3'd2) && (addr[31:8] == 24'hffffff);
        if (dbg) typ = 3'd0;
        chk($sformatf("%s.flush", tag), {31'd0, o_flush}, {31'd0, flush});
        chk($sformatf("%s.type", tag),  {29'd0, o_type},  {29'd0, typ});
        chk($sformatf("%s.debug", tag), {31'd0, o_debug}, {31'd0, dbg});
        chk($sformatf("%s.addr", tag),  o_addr, addr);
        chk($sformatf("%s.pred", tag),  {31'd0, o_pred},  {31'd0, taken});
        chk($sformatf("%s.pcm", tag),   o_pcm, pcm);
        chk($sformatf("%s.mode", tag),  {29'd0, o_mode},  32'd0);
        chk($sformatf("%s.ready", tag), {31'd0, bht_ready}, {31'd0, !m_init});
`ifdef RISCV_I32_FETCH_REQ_BHT_STATS_EN
        chk($sformatf("%s.stat_res", tag), stat_resolved, m_res);
        chk($sformatf("%s.stat_mis", tag), stat_mispredicted, m_mis);
`endif
    endtask

    task automatic set_decode(input logic [2:0] act, input logic [31:0] pc, input logic [3:0] op,
                              input logic comp, input logic imm, input logic [31:0] tgt,
                              input logic en, input logic [2:0] md);
        fetch_action         = act;
        decode_pc            = pc;
        decode_op            = op;
        decode_is_compressed = comp;
        decode_imm_sign      = imm;
        decode_branch_target = tgt;
        enable_bp            = en;
        mode                 = md;
    endtask

    task automatic set_resolve(input logic v, input logic [31:0] pc, input logic t);
        exec_resolve_valid = v;
        exec_resolve_pc    = pc;
        exec_branch_taken  = t;
    endtask

    initial begin
        // act pc op comp imm tgt en md | flush typ dbg addr pred pcm
        vecs[0]  = '{3'd4, 32'h0000_0100, 4'd0, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 3'd3,
                     1'b0, 3'd1, 1'b0, 32'h0000_0080, 1'b1, 32'h0000_0104};
        vecs[1]  = '{3'd4, 32'hFFFF_FFFE, 4'd2, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 3'd3,
                     1'b0, 3'd6, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0040};
        vecs[2]  = '{3'd2, 32'hFFFF_FF10, 4'd2, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 3'd7,
                     1'b1, 3'd0, 1'b1, 32'hFFFF_FF10, 1'b0, 32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FF10, 4'd2, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 3'd3,
                     1'b1, 3'd1, 1'b0, 32'hFFFF_FF10, 1'b0, 32'h0000_0000};
        vecs[4]  = '{3'd3, 32'h0000_0200, 4'd1, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 3'd0,
                     1'b0, 3'd3, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0204};
        vecs[5]  = '{3'd4, 32'h0000_0200, 4'd1, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 3'd0,
                     1'b0, 3'd2, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0300};
        vecs[6]  = '{3'd1, 32'h0000_0200, 4'd1, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 3'd0,
                     1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0204};
        vecs[7]  = '{3'd0, 32'h0000_0200, 4'd1, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 3'd0,
                     1'b1, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0204};
        vecs[8]  = '{3'd5, 32'h0000_0010, 4'd5, 1'b1, 1'b0, 32'h0000_0099, 1'b1, 3'd0,
                     1'b1, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0099};
        vecs[9]  = '{3'd4, 32'h0000_1000, 4'd1, 1'b0, 1'b0, 32'hFFFF_FF80, 1'b1, 3'd7,
                     1'b0, 3'd0, 1'b1, 32'hFFFF_FF80, 1'b1, 32'h0000_1004};
        vecs[10] = '{3'd1, 32'h0000_1000, 4'd1, 1'b0, 1'b0, 32'hFFFF_FF80, 1'b1, 3'd7,
                     1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_1004};
        vecs[11] = '{3'd4, 32'h0000_0300, 4'd0, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 3'd0,
                     1'b0, 3'd6, 1'b0, 32'h0000_0302, 1'b0, 32'h0000_0010};
        vecs[12] = '{3'd3, 32'h0000_0400, 4'd3, 1'b1, 1'b0, 32'h0000_0500, 1'b1, 3'd0,
                     1'b0, 3'd3, 1'b0, 32'h0000_0402, 1'b0, 32'h0000_0500};
        vecs[13] = '{3'd4, 32'h0000_0500, 4'd0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 3'd0,
                     1'b0, 3'd2, 1'b0, 32'h0000_0504, 1'b0, 32'h0000_0020};

        reset_n   = 1'b0;
        bht_flush = 1'b0;
        set_decode(3'd1, 32'd0, 4'd2, 1'b0, 1'b0, 32'd0, 1'b1, 3'd0);
        set_resolve(1'b0, 32'd0, 1'b0);
        model_reset();
        #2;
        chk("reset.ready", {31'd0, bht_ready}, 32'd0);

        // Combinational decode vectors while held in reset (table in INIT).
        for (int i = 0; i < 14; i++) begin
            set_decode(vecs[i].act, vecs[i].pc, vecs[i].op, vecs[i].comp, vecs[i].imm,
                       vecs[i].tgt, vecs[i].en, vecs[i].md);
            #1;
            chk($sformatf("vec%0d.flush", i), {31'd0, o_flush}, {31'd0, vecs[i].flush});
            chk($sformatf("vec%0d.type", i),  {29'd0, o_type},  {29'd0, vecs[i].typ});
            chk($sformatf("vec%0d.debug", i), {31'd0, o_debug}, {31'd0, vecs[i].dbg});
            chk($sformatf("vec%0d.addr", i),  o_addr, vecs[i].addr);
            chk($sformatf("vec%0d.pred", i),  {31'd0, o_pred},  {31'd0, vecs[i].pred});
            chk($sformatf("vec%0d.pcm", i),   o_pcm, vecs[i].pcm);
        end

        // Release reset; INIT must take exactly 16 cycles and ignore resolutions.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        set_decode(3'd4, 32'h100, 4'd0, 1'b0, 1'b1, 32'h80, 1'b1, 3'd3);
        set_resolve(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init.ready_low", {31'd0, bht_ready}, 32'd0);
            chk("init.pred_imm", {31'd0, o_pred}, 32'd1);
            chk("init.addr_target", o_addr, 32'h80);
            check_model("init");
            step();
        end
        chk("init.ready_high", {31'd0, bht_ready}, 32'd1);

        // Train entry for 0x100 taken twice (weak NT -> strong T).
        set_decode(3'd1, 32'h0, 4'd2, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0);
        set_resolve(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            check_model("train");
            step();
        end
        set_resolve(1'b0, 32'h0, 1'b0);
        set_decode(3'd4, 32'h100, 4'd0, 1'b0, 1'b0, 32'h80, 1'b1, 3'd0);
        #1;
        chk("trained.addr", o_addr, 32'h80);
        chk("trained.type", {29'd0, o_type}, 32'd1);
        chk("trained.pcm", o_pcm, 32'h104);
        check_model("trained");

        // Not-taken resolves while decoding the same PC: lookup sees the old value.
        set_resolve(1'b1, 32'h100, 1'b0);
        chk("same_cycle.ctr3", {31'd0, o_pred}, 32'd1);
        step();
        #1;
        chk("same_cycle.ctr2_old", {31'd0, o_pred}, 32'd1);
        check_model("same_cycle");
        step();
        #1;
        chk("after_decrement", {31'd0, o_pred}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_model("sat_low");
            step();
            #1;
        end
        chk("sat_low.pred", {31'd0, o_pred}, 32'd0);
        set_resolve(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_model("sat_high");
            step();
            #1;
        end
        set_resolve(1'b1, 32'h100, 1'b0);
        chk("sat_high.pred", {31'd0, o_pred}, 32'd1);
        step();
        #1;
        chk("sat_high.after_nt", {31'd0, o_pred}, 32'd1);
        check_model("sat_high_nt");
        set_resolve(1'b0, 32'h0, 1'b0);

        // Flush, then flush again when the init index reaches 9.
        bht_flush = 1'b1;
        #1;
        check_model("flush1");
        step();
        bht_flush = 1'b0;
        set_resolve(1'b1, 32'h104, 1'b1);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("reinit.ready_low", {31'd0, bht_ready}, 32'd0);
            check_model("reinit");
            step();
        end
        bht_flush = 1'b1;
        step();
        bht_flush = 1'b0;
`ifdef RISCV_I32_FETCH_REQ_BHT_STATS_EN
        chk("flush.stat_res_zero", stat_resolved, 32'd0);
        chk("flush.stat_mis_zero", stat_mispredicted, 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("flush9.ready_low", {31'd0, bht_ready}, 32'd0);
            check_model("flush9");
            step();
        end
        chk("flush9.ready_high", {31'd0, bht_ready}, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            bht_flush = ($urandom_range(0, 99) == 0);
            fetch_action = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0)
                decode_pc = 32'h100 + 32'($urandom_range(0, 15)) * 32'd2;
            else if ($urandom_range(0, 2) == 0)
                decode_pc = {24'hffffff, 8'($urandom)};
            else
                decode_pc = $urandom;
            decode_op            = 4'($urandom_range(0, 5));
            decode_is_compressed = 1'($urandom_range(0, 1));
            decode_imm_sign      = 1'($urandom_range(0, 1));
            decode_branch_target = ($urandom_range(0, 3) == 0) ? {24'hffffff, 8'($urandom)} : $urandom;
            enable_bp            = ($urandom_range(0, 7) != 0);
            mode                 = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            exec_resolve_valid   = 1'($urandom_range(0, 1));
            exec_resolve_pc      = 32'h100 + 32'($urandom_range(0, 15)) * 32'd2;
            exec_branch_taken    = 1'($urandom_range(0, 1));
            #1;
            check_model("rand");
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
